// File: rtl/vm_pkg.sv
// vm_pkg: shared FSM state encoding and default coin denomination table
package vm_pkg;
  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;
  localparam logic [31:0] DEF_DENOMS = {8'd1, 8'd2, 8'd5, 8'd10};
endpackage

// File: rtl/denom_select.sv
// denom_select: priority pick of the largest coin that fits the remaining change and is in stock
module denom_select #(
  parameter int AMT_W = 8,
  parameter int NUM_DENOM = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 6,
  parameter logic [NUM_DENOM*AMT_W-1:0] DENOMS = vm_pkg::DEF_DENOMS
) (
  input  logic [AMT_W-1:0]           i_rem,
  input  logic [NUM_DENOM*CNT_W-1:0] i_inv,
  output logic                       o_found,
  output logic [IDX_W-1:0]           o_idx
);
  // scan from the smallest coin upwards so the lowest fitting index wins
  always_comb begin
    o_found = 1'b0;
    o_idx = '0;
    for (int k = NUM_DENOM - 1; k >= 0; k--)
      if (DENOMS[k*AMT_W +: AMT_W] <= i_rem && i_inv[k*CNT_W +: CNT_W] != '0) begin
        o_found = 1'b1;
        o_idx = IDX_W'(k);
      end
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change breakdown against live inventory, one coin per hopper handshake
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int NUM_DENOM = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 6,
  parameter logic [NUM_DENOM*AMT_W-1:0] DENOMS = DEF_DENOMS,
  parameter logic [CNT_W-1:0] INIT_CNT = 6'd10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [AMT_W-1:0]           paid_amt,
  input  logic [AMT_W-1:0]           price,
  output logic                       coin_valid,
  output logic [IDX_W-1:0]           coin_idx,
  input  logic                       coin_ready,
  input  logic                       refill_en,
  input  logic [IDX_W-1:0]           refill_idx,
  input  logic [CNT_W-1:0]           refill_cnt,
  output logic                       busy,
  output logic                       done,
  output logic [AMT_W-1:0]           change_total,
  output logic [AMT_W-1:0]           shortfall,
  output logic                       err_insufficient,
  output logic                       err_no_change,
  output logic [NUM_DENOM*CNT_W-1:0] inv_cnt
);
  state_t r_state, w_state;
  logic [AMT_W-1:0] r_rem, w_rem, r_total, w_total, r_short, w_short;
  logic r_valid, w_valid, r_done, w_done, r_busy, w_busy, r_ins, w_ins, r_nc, w_nc;
  logic [IDX_W-1:0] r_idx, w_idx, w_pick;
  logic [NUM_DENOM*CNT_W-1:0] r_inv, w_inv;
  logic w_found;
  logic [CNT_W:0] w_sum;

  assign w_sum = {1'b0, r_inv[refill_idx*CNT_W +: CNT_W]} + {1'b0, refill_cnt};

  denom_select #(.AMT_W(AMT_W), .NUM_DENOM(NUM_DENOM), .IDX_W(IDX_W), .CNT_W(CNT_W), .DENOMS(DENOMS)) u_sel (
    .i_rem(r_rem),
    .i_inv(r_inv),
    .o_found(w_found),
    .o_idx(w_pick)
  );

  // next state and next registered outputs
  always_comb begin
    w_state = r_state;
    w_rem = r_rem;
    w_total = r_total;
    w_short = r_short;
    w_valid = r_valid;
    w_idx = r_idx;
    w_ins = r_ins;
    w_nc = r_nc;
    w_inv = r_inv;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (refill_en && 32'(refill_idx) < NUM_DENOM)
          w_inv[refill_idx*CNT_W +: CNT_W] = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        if (start) begin
          w_ins = paid_amt < price;
          w_nc = 1'b0;
          w_short = '0;
          w_total = w_ins ? '0 : paid_amt - price;
          w_rem = w_total;
          w_state = w_ins ? DONE : SELECT;
        end
      end
      SELECT: begin
        if (r_rem == '0) w_state = DONE;
        else if (w_found) begin
          w_idx = w_pick;
          w_valid = 1'b1;
          w_state = DISPENSE;
        end else begin
          w_short = r_rem;
          w_nc = 1'b1;
          w_state = DONE;
        end
      end
      DISPENSE: begin
        if (coin_ready) begin
          w_inv[r_idx*CNT_W +: CNT_W] = r_inv[r_idx*CNT_W +: CNT_W] - CNT_W'(1);
          w_rem = r_rem - DENOMS[r_idx*AMT_W +: AMT_W];
          w_valid = 1'b0;
          w_state = SELECT;
        end
      end
      default: begin
        w_done = 1'b1;
        w_state = IDLE;
      end
    endcase
    w_busy = w_state != IDLE;
  end

  // state and output registers; reset restocks every denomination
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem <= '0;
      r_total <= '0;
      r_short <= '0;
      r_valid <= 1'b0;
      r_idx <= '0;
      r_ins <= 1'b0;
      r_nc <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_inv <= {NUM_DENOM{INIT_CNT}};
    end else begin
      r_state <= w_state;
      r_rem <= w_rem;
      r_total <= w_total;
      r_short <= w_short;
      r_valid <= w_valid;
      r_idx <= w_idx;
      r_ins <= w_ins;
      r_nc <= w_nc;
      r_done <= w_done;
      r_busy <= w_busy;
      r_inv <= w_inv;
    end
  end

  assign coin_valid = r_valid;
  assign coin_idx = r_idx;
  assign busy = r_busy;
  assign done = r_done;
  assign change_total = r_total;
  assign shortfall = r_short;
  assign err_insufficient = r_ins;
  assign err_no_change = r_nc;
  assign inv_cnt = r_inv;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vectors with hand-computed coin sequences and inventory
module tb_change_dispenser;
  logic clk = 0, rst_n = 0, start = 0, coin_ready = 1, refill_en = 0;
  logic [7:0] paid_amt = 0, price = 0;
  logic [1:0] refill_idx = 0;
  logic [5:0] refill_cnt = 0;
  logic coin_valid, busy, done, err_insufficient, err_no_change;
  logic [1:0] coin_idx;
  logic [7:0] change_total, shortfall;
  logic [23:0] inv_cnt;
  int checks = 0, errors = 0, ndone = 0, nvalid = 0, lat;
  logic [1:0] coins[$];
  logic [1:0] held;
  logic [23:0] inv_held;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .paid_amt(paid_amt), .price(price),
    .coin_valid(coin_valid), .coin_idx(coin_idx), .coin_ready(coin_ready),
    .refill_en(refill_en), .refill_idx(refill_idx), .refill_cnt(refill_cnt),
    .busy(busy), .done(done), .change_total(change_total), .shortfall(shortfall),
    .err_insufficient(err_insufficient), .err_no_change(err_no_change), .inv_cnt(inv_cnt)
  );

  always #5 clk = ~clk;

  // handshake and done monitor, sampled mid-cycle
  always @(negedge clk)
    if (rst_n) begin
      if (coin_valid) nvalid++;
      if (coin_valid && coin_ready) coins.push_back(coin_idx);
      if (done) ndone++;
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] coin_word();
    logic [31:0] w = 0;
    foreach (coins[k]) w |= 32'(coins[k]) << (2 * k);
    return w;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic req(input logic [7:0] p, input logic [7:0] pr, output int l);
    coins.delete(); ndone = 0; nvalid = 0;
    @(posedge clk); #1 start = 1; paid_amt = p; price = pr;
    @(posedge clk); #1 start = 0;
    l = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin l = i; break; end
    end
    if (l < 0) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", coin_valid, 0);
    check("rst_total", change_total, 0);
    check("rst_inv", inv_cnt, {6'd10, 6'd10, 6'd10, 6'd10});

    req(37, 12, lat);
    check("c37_n", coins.size(), 3);
    check("c37_seq", coin_word(), 32'h10);
    check("c37_total", change_total, 25);
    check("c37_short", shortfall, 0);
    check("c37_err", {err_insufficient, err_no_change}, 0);
    check("c37_inv", inv_cnt, {6'd10, 6'd10, 6'd9, 6'd8});
    check("c37_done", ndone, 1);

    req(20, 20, lat);
    check("eq_lat", lat, 2);
    check("eq_coins", nvalid, 0);
    check("eq_total", change_total, 0);

    do_reset();
    req(90, 0, lat);
    check("d90_n", coins.size(), 9);
    check("d90_inv", inv_cnt, {6'd10, 6'd10, 6'd10, 6'd1});
    req(37, 12, lat);
    check("low10_n", coins.size(), 4);
    check("low10_seq", coin_word(), 32'd84);
    check("low10_err", {err_insufficient, err_no_change}, 0);
    check("low10_done", ndone, 1);
    check("low10_inv", inv_cnt, {6'd10, 6'd10, 6'd7, 6'd0});

    do_reset();
    for (int i = 0; i < 10; i++) req(1, 0, lat);
    for (int i = 0; i < 10; i++) req(2, 0, lat);
    check("drain_inv", inv_cnt, {6'd0, 6'd0, 6'd10, 6'd10});
    req(3, 0, lat);
    check("nc3_coins", nvalid, 0);
    check("nc3_err", err_no_change, 1);
    check("nc3_short", shortfall, 3);
    req(8, 0, lat);
    check("nc8_seq", {coins.size(), coin_word()}, {32'd1, 32'd1});
    check("nc8_short", shortfall, 3);
    check("nc8_err", err_no_change, 1);
    req(10, 0, lat);
    check("clr_err", err_no_change, 0);
    check("clr_short", shortfall, 0);

    req(5, 9, lat);
    check("ins_err", err_insufficient, 1);
    check("ins_total", change_total, 0);
    check("ins_coins", nvalid, 0);
    check("ins_done", ndone, 1);

    do_reset();
    coins.delete(); ndone = 0;
    @(posedge clk); #1 coin_ready = 0; start = 1; paid_amt = 37; price = 12;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_valid0", coin_valid, 1);
    held = coin_idx; inv_held = inv_cnt;
    check("stall_idx0", held, 0);
    @(posedge clk); #1 start = 1; paid_amt = 99; price = 0; refill_en = 1; refill_idx = 0; refill_cnt = 5;
    @(posedge clk); #1 start = 0; refill_en = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {coin_valid, coin_idx, inv_cnt}, {1'b1, held, inv_held});
    end
    @(posedge clk); #1 coin_ready = 1;
    for (int i = 0; i < 100 && ndone == 0; i++) @(negedge clk);
    check("stall_done", ndone, 1);
    check("stall_seq", coin_word(), 32'h10);
    check("stall_total", change_total, 25);
    check("stall_inv", inv_cnt, {6'd10, 6'd10, 6'd9, 6'd8});

    @(posedge clk); #1 coin_ready = 0; start = 1; paid_amt = 37; price = 12;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1; coin_ready = 1;
    @(negedge clk);
    check("mid_rst_valid", coin_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_inv", inv_cnt, {6'd10, 6'd10, 6'd10, 6'd10});

    @(posedge clk); #1 refill_en = 1; refill_idx = 3; refill_cnt = 60;
    @(posedge clk); #1 refill_en = 0;
    @(negedge clk);
    check("refill_sat", inv_cnt, {6'd63, 6'd10, 6'd10, 6'd10});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
